if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: data width, reset vector, IF FSM encodings
// and the sequential PC increment.
package rv32i_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, single-entry output buffer,
// redirect-driven squash. Optional macro IF_MISALIGN_CHK_EN turns misaligned redirect
// targets into fault entries instead of silently aligning them.
//
// state   | meaning
// IF_IDLE | post-reset launch, or parked after a misaligned-target fault
// IF_REQ  | request for pc presented, waiting for imem_req_ready
// IF_WAIT | one request outstanding; drop=1 means its response is discarded
// IF_HOLD | instruction (or fault entry) presented to decode
module if_stage #(
  parameter int                XLEN     = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(rv32i_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misalign
);
  import rv32i_pkg::*;

  if_state_t       state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pc_q, pc_q_nxt;
  logic [XLEN-1:0] instr_q, instr_q_nxt;
  logic            drop, drop_nxt;
  logic            mis_q, mis_q_nxt;
  logic [XLEN-1:0] target;
  logic            redir_mis;

`ifdef IF_MISALIGN_CHK_EN
  assign target    = redirect_pc;
  assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign target    = redirect_pc & ~XLEN'(3);
  assign redir_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IF_IDLE;
      pc      <= RESET_PC;
      pc_q    <= '0;
      instr_q <= '0;
      drop    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pc_q    <= pc_q_nxt;
      instr_q <= instr_q_nxt;
      drop    <= drop_nxt;
      mis_q   <= mis_q_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pc_q_nxt    = pc_q;
    instr_q_nxt = instr_q;
    drop_nxt    = drop;
    mis_q_nxt   = mis_q;
    unique case (state)
      IF_IDLE: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          mis_q_nxt = 1'b0;
          state_nxt = IF_REQ;
        end else if (!mis_q) begin
          state_nxt = IF_REQ;
        end
      end
      IF_REQ: begin
        if (redirect_valid) pc_nxt = target;
        if (imem_req_ready) begin
          state_nxt = IF_WAIT;
          drop_nxt  = redirect_valid;
        end
      end
      IF_WAIT: begin
        if (redirect_valid) pc_nxt = target;
        if (imem_rsp_valid) begin
          drop_nxt = 1'b0;
          if (redirect_valid || drop) begin
            state_nxt = IF_REQ;
          end else begin
            pc_q_nxt    = pc;
            instr_q_nxt = imem_rsp_data;
            state_nxt   = IF_HOLD;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      IF_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = IF_REQ;
        end else if (if_ready) begin
          pc_nxt    = pc + XLEN'(PC_INC);
          // An accepted fault entry parks the stage until execute redirects it.
          state_nxt = mis_q ? IF_IDLE : IF_REQ;
        end
      end
      default: state_nxt = IF_IDLE;
    endcase
    if (redir_mis) begin
      pc_nxt      = redirect_pc;
      pc_q_nxt    = redirect_pc;
      instr_q_nxt = '0;
      mis_q_nxt   = 1'b1;
      drop_nxt    = 1'b0;
      state_nxt   = IF_HOLD;
    end
  end

  assign imem_req_valid = (state == IF_REQ);
  assign imem_req_addr  = pc;
  assign if_valid       = (state == IF_HOLD);
  assign if_pc          = pc_q;
  assign if_instr       = instr_q;
`ifdef IF_MISALIGN_CHK_EN
  assign if_misalign    = mis_q && (state == IF_HOLD);
`else
  assign if_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a latency-programmable imem responder, expected
// request-address and decode-output queues filled by the stimulus, popped on handshakes.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } out_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rsp_lat = 1;
  logic        spacing_en = 1'b0;
  int          last_hs = -1;
  logic [31:0] exp_req_q[$];
  out_t        exp_out_q[$];
  pend_t       pend_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h10 || a == 32'h104 || a == 32'h184) return 32'hDEAD_BEEF;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
    out_t o;
    o.pc = pc;
    o.instr = instr;
    o.mis = mis;
    exp_out_q.push_back(o);
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc);
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (if_valid && if_pc == pc) found = 1'b1;
    end
    chk("tmo_valid_pc", 32'(found), 32'd1);
  endtask

  task automatic wait_acc(input logic [31:0] addr);
    logic found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && imem_req_addr == addr) found = 1'b1;
    end
    chk("tmo_req_acc", 32'(found), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory response driver
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      imem_rsp_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end
  end

  // request acceptance and decode handshake monitor
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        pend_t p;
        int sz;
        p.addr = imem_req_addr;
        p.due  = cyc + rsp_lat;
        pend_q.push_back(p);
        sz = exp_req_q.size();
        if (sz == 0) chk("req_unexpected", 32'(sz), 32'd1);
        else chk("req_addr", imem_req_addr, exp_req_q.pop_front());
      end
      if (if_valid && if_ready && !redirect_valid) begin
        int sz;
        sz = exp_out_q.size();
        if (sz == 0) begin
          chk("out_unexpected", 32'(sz), 32'd1);
        end else begin
          out_t o;
          o = exp_out_q.pop_front();
          chk("out_pc", if_pc, o.pc);
          chk("out_instr", if_instr, o.instr);
          chk("out_misalign", 32'(if_misalign), 32'(o.mis));
        end
        if (spacing_en && last_hs >= 0) chk("spacing", 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_misalign", 32'(if_misalign), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();

    // free-running fetch after reset release: 0,4,8 one per 3 cycles
    for (int i = 0; i < 4; i++) exp_req_q.push_back(32'(i * 4));
    for (int i = 0; i < 3; i++) push_out(32'(i * 4), mem_data(32'(i * 4)), 1'b0);
    step();
    rst = 1'b0;
    spacing_en = 1'b1;
    wait_valid_pc(32'h8);
    step();
    spacing_en = 1'b0;
    if_ready = 1'b0;

    // decode stall: 0xC held stable, 0x10 not requested
    push_out(32'hC, mem_data(32'hC), 1'b0);
    exp_req_q.push_back(32'h10);
    wait_valid_pc(32'hC);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", if_pc, 32'hC);
      chk("stall_instr", if_instr, mem_data(32'hC));
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
    end
    step();
    if_ready = 1'b1;

    // redirect in WAIT coincident with the DEADBEEF response
    exp_req_q.push_back(32'h100);
    push_out(32'h100, mem_data(32'h100), 1'b0);
    wait_acc(32'h10);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;

    // redirect in WAIT before a slow response: response dropped
    exp_req_q.push_back(32'h104);
    exp_req_q.push_back(32'h180);
    push_out(32'h180, mem_data(32'h180), 1'b0);
    wait_valid_pc(32'h100);
    step();
    rsp_lat = 3;
    wait_acc(32'h104);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h180;
    step();
    redirect_valid = 1'b0;
    rsp_lat = 1;

    // redirect coincident with request acceptance
    exp_req_q.push_back(32'h184);
    exp_req_q.push_back(32'h300);
    push_out(32'h300, mem_data(32'h300), 1'b0);
    wait_valid_pc(32'h180);
    wait_acc(32'h184);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;

    // redirect in HOLD coincident with decode accept: no pc+4
    exp_req_q.push_back(32'h304);
    exp_req_q.push_back(32'h200);
    push_out(32'h200, mem_data(32'h200), 1'b0);
    wait_valid_pc(32'h300);
    step();
    if_ready = 1'b0;
    wait_valid_pc(32'h304);
    step();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;

    // redirect in REQ without acceptance, then PC wrap from FFFF_FFFC
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0);
    push_out(32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC), 1'b0);
    push_out(32'h0, mem_data(32'h0), 1'b0);
    wait_valid_pc(32'h200);
    step();
    imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("abort_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    imem_req_ready = 1'b1;
    wait_valid_pc(32'hFFFF_FFFC);
    wait_valid_pc(32'h0);

    // misaligned redirect target 0x102
    exp_req_q.push_back(32'h4);
`ifdef IF_MISALIGN_CHK_EN
    push_out(32'h102, 32'h0, 1'b1);
`else
    exp_req_q.push_back(32'h100);
`endif
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    wait_valid_pc(32'h102);
    repeat (3) @(negedge clk);
    chk("fault_parked", 32'(imem_req_valid), 32'd0);
    exp_req_q.push_back(32'h100);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
`endif
    push_out(32'h100, mem_data(32'h100), 1'b0);

    // reset mid-WAIT; the late response lands in REQ and is ignored
    exp_req_q.push_back(32'h104);
    exp_req_q.push_back(32'h0);
    push_out(32'h0, mem_data(32'h0), 1'b0);
    wait_valid_pc(32'h100);
    step();
    rsp_lat = 4;
    wait_acc(32'h104);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk_reset_outputs();
    step();
    rst = 1'b0;
    wait_valid_pc(32'h0);
    step();
    imem_req_ready = 1'b0;
    repeat (8) @(negedge clk);

    chk("req_q_left", 32'(exp_req_q.size()), 32'd0);
    chk("out_q_left", 32'(exp_out_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
